// File: rtl/contador_modular.sv
// Modular up/down counter driven by asynchronous push-button levels, with wrap or saturate boundaries.
// Defining CONTADOR_LOAD_EN adds a synchronous parallel load (load, load_value) that overrides steps.
module contador_modular #(
  parameter int WIDTH    = 6,
  parameter int MODULUS  = 2**WIDTH,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             increment,
  input  logic             decrement,
`ifdef CONTADOR_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
`endif
  output logic [WIDTH-1:0] count,
  output logic             terminal,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_C = WIDTH'(0);
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

  logic [1:0]       inc_sync_q;
  logic [1:0]       dec_sync_q;
  logic             inc_hist_q;
  logic             dec_hist_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             terminal_q;
  logic             terminal_d;
  logic             at_max_q;
  logic             at_zero_q;
  logic             up_s;
  logic             dn_s;
  logic [WIDTH-1:0] step_count_s;
  logic             step_term_s;

  assign up_s = inc_sync_q[1] & ~inc_hist_q;
  assign dn_s = dec_sync_q[1] & ~dec_hist_q;

  // Boundary handling for a single step; simultaneous up and down cancel.
  always_comb begin
    step_count_s = count_q;
    step_term_s  = 1'b0;
    case ({up_s, dn_s})
      2'b10: begin
        if (count_q != MAX_C) begin
          step_count_s = count_q + ONE_C;
        end else if (SATURATE) begin
          step_count_s = count_q;
        end else begin
          step_count_s = ZERO_C;
          step_term_s  = 1'b1;
        end
      end
      2'b01: begin
        if (count_q != ZERO_C) begin
          step_count_s = count_q - ONE_C;
        end else if (SATURATE) begin
          step_count_s = count_q;
        end else begin
          step_count_s = MAX_C;
          step_term_s  = 1'b1;
        end
      end
      default: begin
        step_count_s = count_q;
        step_term_s  = 1'b0;
      end
    endcase
  end

  // Load wins over a coincident step and suppresses its terminal pulse.
  always_comb begin
    count_d    = step_count_s;
    terminal_d = step_term_s;
`ifdef CONTADOR_LOAD_EN
    if (load) begin
      count_d    = (load_value > MAX_C) ? MAX_C : load_value;
      terminal_d = 1'b0;
    end else begin
      count_d    = step_count_s;
      terminal_d = step_term_s;
    end
`endif
  end

  // Synchronisers reset high so a level already high at release is not a step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inc_sync_q <= 2'b11;
      dec_sync_q <= 2'b11;
      inc_hist_q <= 1'b1;
      dec_hist_q <= 1'b1;
      count_q    <= ZERO_C;
      terminal_q <= 1'b0;
      at_max_q   <= 1'b0;
      at_zero_q  <= 1'b1;
    end else begin
      inc_sync_q <= {inc_sync_q[0], increment};
      dec_sync_q <= {dec_sync_q[0], decrement};
      inc_hist_q <= inc_sync_q[1];
      dec_hist_q <= dec_sync_q[1];
      count_q    <= count_d;
      terminal_q <= terminal_d;
      at_max_q   <= (count_d == MAX_C);
      at_zero_q  <= (count_d == ZERO_C);
    end
  end

  assign count    = count_q;
  assign terminal = terminal_q;
  assign at_max   = at_max_q;
  assign at_zero  = at_zero_q;

endmodule

// File: tb/tb_contador_modular.sv
// Self-checking bench: a wrap counter (MODULUS=60) and a saturating counter (MODULUS=4) share stimulus
// and are compared every cycle against an arithmetic reference model, plus directed corner cases.
module tb_contador_modular;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic       load = 1'b0;
  logic [5:0] load_value = 6'd0;
  logic [5:0] count_w;
  logic [1:0] count_s;
  logic       term_w, term_s, max_w, max_s, zero_w, zero_s;

  int tests = 0;
  int fails = 0;
  int t = 0;
  int hits_w = 0;
  int hits_s = 0;
  bit prev_inc = 1'b1;
  bit prev_dec = 1'b1;
  bit up_at [0:4095];
  bit dn_at [0:4095];
  int mc [2];
  bit mt [2];
  int mod_of [2] = '{60, 4};
  bit sat_of [2] = '{1'b0, 1'b1};

  typedef struct {
    bit i;
    bit d;
    int exp_count;
    bit exp_term;
  } vec_t;
  vec_t vecs [31];

  always #5 clk = ~clk;

  contador_modular #(.WIDTH(6), .MODULUS(60), .SATURATE(1'b0)) dut_w (
    .clk(clk), .reset(rst_n), .increment(inc), .decrement(dec),
`ifdef CONTADOR_LOAD_EN
    .load(load), .load_value(load_value),
`endif
    .count(count_w), .terminal(term_w), .at_max(max_w), .at_zero(zero_w)
  );

  contador_modular #(.WIDTH(2), .MODULUS(4), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset(rst_n), .increment(inc), .decrement(dec),
`ifdef CONTADOR_LOAD_EN
    .load(load), .load_value(load_value[1:0]),
`endif
    .count(count_s), .terminal(term_s), .at_max(max_s), .at_zero(zero_s)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference behaviour of one clock edge for counter k.
  task automatic model_edge(input int k, input bit u, input bit d, input bit ld, input int lv);
    int m;
    m = mod_of[k];
    mt[k] = 1'b0;
    if (ld) begin
      mc[k] = (lv > m - 1) ? m - 1 : lv;
    end else if (u && !d) begin
      if (mc[k] < m - 1) mc[k] = mc[k] + 1;
      else if (!sat_of[k]) begin
        mc[k] = 0;
        mt[k] = 1'b1;
      end
    end else if (d && !u) begin
      if (mc[k] > 0) mc[k] = mc[k] - 1;
      else if (!sat_of[k]) begin
        mc[k] = m - 1;
        mt[k] = 1'b1;
      end
    end
  endtask

  task automatic tick(input bit i, input bit d, input bit ld, input int lv);
    @(negedge clk);
    inc = i;
    dec = d;
    load = ld;
    load_value = 6'(lv);
    if (i && !prev_inc) up_at[t + 2] = 1'b1;
    if (d && !prev_dec) dn_at[t + 2] = 1'b1;
    prev_inc = i;
    prev_dec = d;
    @(posedge clk);
    #1;
    model_edge(0, up_at[t], dn_at[t], ld, lv & 63);
    model_edge(1, up_at[t], dn_at[t], ld, lv & 3);
    if (term_w) hits_w++;
    if (term_s) hits_s++;
    check("w_count", count_w, mc[0]);
    check("w_terminal", term_w, mt[0]);
    check("w_at_max", max_w, (mc[0] == 59) ? 1 : 0);
    check("w_at_zero", zero_w, (mc[0] == 0) ? 1 : 0);
    check("s_count", count_s, mc[1]);
    check("s_terminal", term_s, mt[1]);
    check("s_at_max", max_s, (mc[1] == 3) ? 1 : 0);
    check("s_at_zero", zero_s, (mc[1] == 0) ? 1 : 0);
    t++;
  endtask

  task automatic reset_assert();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mc[k] = 0;
      mt[k] = 1'b0;
    end
    for (int j = 0; j < 4; j++) begin
      up_at[t + j] = 1'b0;
      dn_at[t + j] = 1'b0;
    end
  endtask

  task automatic reset_release(input bit i, input bit d);
    @(negedge clk);
    rst_n = 1'b1;
    inc = i;
    dec = d;
    load = 1'b0;
    prev_inc = i;
    prev_dec = d;
  endtask

  task automatic full_reset();
    @(negedge clk);
    inc = 1'b0;
    dec = 1'b0;
    reset_assert();
    #1;
    check("rst_count", count_w, 0);
    check("rst_at_zero", zero_w, 1);
    reset_release(1'b0, 1'b0);
  endtask

  task automatic pulses(input bit up, input int n);
    for (int p = 0; p < n; p++) begin
      tick(up, !up, 1'b0, 0);
      tick(1'b0, 1'b0, 1'b0, 0);
    end
    repeat (3) tick(1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 20; i++) vecs[i] = '{1'b1, 1'b0, (i < 2) ? 0 : 1, 1'b0};
    for (int i = 20; i < 23; i++) vecs[i] = '{1'b0, 1'b0, 1, 1'b0};
    for (int i = 23; i < 28; i++) vecs[i] = '{1'b1, 1'b1, 1, 1'b0};
    for (int i = 28; i < 31; i++) vecs[i] = '{1'b0, 1'b0, 1, 1'b0};

    // Asynchronous reset before any clock edge.
    #2;
    reset_assert();
    #1;
    check("init_count", count_w, 0);
    check("init_terminal", term_w, 0);
    check("init_at_max", max_w, 0);
    check("init_at_zero", zero_w, 1);
    check("init_s_count", count_s, 0);
    reset_release(1'b0, 1'b0);

    // Wrap at the top.
    pulses(1'b1, 59);
    check("w59_count", count_w, 59);
    check("w59_at_max", max_w, 1);
    hits_w = 0;
    pulses(1'b1, 1);
    check("w60_count", count_w, 0);
    check("w60_terminal_pulses", hits_w, 1);
    check("w60_at_zero", zero_w, 1);

    // Wrap at the bottom.
    full_reset();
    hits_w = 0;
    pulses(1'b0, 1);
    check("dn_count", count_w, 59);
    check("dn_terminal_pulses", hits_w, 1);
    check("dn_at_zero", zero_w, 0);

    // Saturation.
    full_reset();
    hits_s = 0;
    pulses(1'b1, 6);
    check("sat_up_count", count_s, 3);
    check("sat_up_at_max", max_s, 1);
    pulses(1'b0, 5);
    check("sat_dn_count", count_s, 0);
    check("sat_terminal_pulses", hits_s, 0);

    // Held input steps once on the 3rd edge; simultaneous requests cancel.
    full_reset();
    foreach (vecs[i]) begin
      tick(vecs[i].i, vecs[i].d, 1'b0, 0);
      check($sformatf("vec%0d_count", i), count_w, vecs[i].exp_count);
      check($sformatf("vec%0d_terminal", i), term_w, vecs[i].exp_term);
    end

    // Reset between edges, then increment held across release.
    full_reset();
    pulses(1'b1, 5);
    check("pre_rst_count", count_w, 5);
    #3;
    inc = 1'b1;
    reset_assert();
    #1;
    check("mid_rst_count", count_w, 0);
    check("mid_rst_at_zero", zero_w, 1);
    reset_release(1'b1, 1'b0);
    repeat (10) tick(1'b1, 1'b0, 1'b0, 0);
    check("held_rst_count", count_w, 0);
    tick(1'b0, 1'b0, 1'b0, 0);

    // Random stimulus against the model.
    for (int r = 0; r < 600; r++) begin
      bit ri, rd, rl;
      ri = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 2) == 0);
      rl = 1'b0;
`ifdef CONTADOR_LOAD_EN
      rl = ($urandom_range(0, 19) == 0);
`endif
      tick(ri, rd, rl, int'($urandom_range(0, 63)));
    end

`ifdef CONTADOR_LOAD_EN
    // Load clamps and overrides a coincident step.
    full_reset();
    tick(1'b0, 1'b0, 1'b1, 63);
    check("load63_count", count_w, 59);
    check("load63_at_max", max_w, 1);
    tick(1'b1, 1'b0, 1'b0, 0);
    tick(1'b1, 1'b0, 1'b0, 0);
    tick(1'b1, 1'b0, 1'b1, 10);
    check("load_step_count", count_w, 10);
    check("load_step_terminal", term_w, 0);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 0);
    check("load_step_lost", count_w, 10);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/contador_modular.md
CONTADOR_MODULAR -- requirements
Module: contador_modular

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, giving the count width in bits (legal range 2..16).
REQ-002 The block SHALL have parameter MODULUS, default 2**WIDTH, so the count range is 0..MODULUS-1 (legal range 2..2**WIDTH).
REQ-003 The block SHALL have parameter SATURATE, default 0: 0 selects wrap mode, 1 selects saturate mode.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port increment, input, 1 bit: asynchronous level request (push-button); each rising edge requests one up-step.
REQ-007 The block SHALL have port decrement, input, 1 bit: asynchronous level request; each rising edge requests one down-step.
REQ-008 The block SHALL have port count, output, WIDTH bits: the current count value.
REQ-009 The block SHALL have port terminal, output, 1 bit: one-cycle pulse on a wrap event.
REQ-010 The block SHALL have ports at_max and at_zero, output, 1 bit each: registered flags meaning count==MODULUS-1 and count==0.

Function
REQ-011 The block SHALL pass increment and decrement through a two-flop synchroniser and then a third history flop each; a step event is synchronised-high AND history-low.
REQ-012 A step SHALL update count on the 3rd rising clk edge after the input rises (input stable before edge 1); the flags follow on the same edge.
REQ-013 Holding an input high for any number of cycles SHALL produce exactly one step; a new step requires the input to fall and rise again.
REQ-014 Simultaneous up and down step events in the same cycle SHALL cancel: count unchanged, terminal 0.
REQ-015 In wrap mode, an up-step at MODULUS-1 SHALL give 0 and a down-step at 0 SHALL give MODULUS-1, with terminal high for exactly that one cycle.
REQ-016 In saturate mode, an up-step at MODULUS-1 or a down-step at 0 SHALL leave count unchanged, and terminal SHALL never assert.
REQ-017 Outside the boundaries, an up-step SHALL give count+1 and a down-step count-1, with terminal 0.
REQ-018 count SHALL never hold a value at or above MODULUS.
REQ-019 at_max and at_zero SHALL always be consistent with count in the same cycle.

Reset
REQ-020 While reset is low, count, terminal and at_max SHALL be 0 and at_zero SHALL be 1, immediately and without waiting for clk.
REQ-021 Reset SHALL force all synchroniser and history flops to 1, so an input held high across reset release produces no step.
REQ-022 Reset asserted mid-operation SHALL discard any pending step in the synchroniser pipeline.
REQ-023 After reset is released, the first step SHALL take effect only after the input is seen low and then high again.

Configuration
REQ-024 The block SHALL use the macro CONTADOR_LOAD_EN to compile in a parallel-load feature.
REQ-025 When CONTADOR_LOAD_EN is defined, the block SHALL add ports load (input, 1 bit, synchronous) and load_value (input, WIDTH bits).
REQ-026 When CONTADOR_LOAD_EN is defined, load high at an edge SHALL set count to load_value, clamped to MODULUS-1 if load_value >= MODULUS.
REQ-027 When CONTADOR_LOAD_EN is defined, load SHALL take priority over any step in the same cycle; that step is lost and terminal is 0.
REQ-028 When CONTADOR_LOAD_EN is undefined, the block SHALL have neither port nor load logic, and all other behaviour SHALL be identical.

Verification
REQ-029 Bench SHALL check: WIDTH=6, MODULUS=60, wrap mode; 59 increment pulses from reset -> count=59, at_max=1; one more pulse -> count=0 with a 1-cycle terminal pulse.
REQ-030 Bench SHALL check: same configuration, from reset one decrement pulse -> count=59, terminal pulses, at_zero falls.
REQ-031 Bench SHALL check: SATURATE=1, MODULUS=4; 6 increment pulses -> count=3 with terminal never high; 5 decrement pulses -> count=0.
REQ-032 Bench SHALL check: increment held high for 20 cycles -> count 0->1 only, changing on the 3rd edge; increment and decrement raised together -> count unchanged.
REQ-033 Bench SHALL check: reset pulled low between clock edges at count=5 -> count=0 and at_zero=1 before the next edge; increment held high through reset release -> count stays 0.
REQ-034 Bench SHALL check with CONTADOR_LOAD_EN defined and MODULUS=60: load_value=63 with load high -> count=59; load together with an increment step -> count=load_value and the step is lost.
